alu_serial_ctrl: RTL and testbench
==================================

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled only when ready=1.
REQ-005 command  input  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
REQ-006 a  input  WIDTH  operand A, two's complement.
REQ-007 b  input  WIDTH  operand B, two's complement.
REQ-008 ready  output  1  controller idle; a start is accepted this cycle.
REQ-009 done  output  1  one-cycle pulse: result and flags updated.
REQ-010 result  output  WIDTH  registered operation result.
REQ-011 carryout  output  1  carry out of the MSB for ADD, SUB and SLT; 0 otherwise.
REQ-012 overflow  output  1  signed overflow for ADD, SUB and SLT; 0 otherwise.
REQ-013 zero  output  1  1 iff result == 0.

Function
REQ-014 The block SHALL compute the WIDTH-bit operation bit-serially, LSB first, through exactly one instance of the team's 1-bit ALU slice.
- Slice command = latched command.
- Slice invtb = 1 for SUB and SLT, else 0.
- Slice cin = carry register.
REQ-015 FSM states SHALL be IDLE, RUN and FIN.
- IDLE->RUN on start=1.
- RUN->FIN after bit WIDTH-1 is processed.
- FIN->IDLE unconditionally.
REQ-016 On the accepting edge E0, the block SHALL:
- latch a, b and command;
- clear the bit index;
- load the carry register with invtb (1 for SUB/SLT, else 0);
- clear the internal result shift register.
REQ-017 At each RUN edge E1..EWIDTH, bit index i SHALL:
- capture the slice result bit into position i;
- capture the slice cout into the carry register;
- capture the carry into bit i (needed for overflow at i = WIDTH-1);
- increment i.
REQ-018 At edge EWIDTH+1 (FIN), the block SHALL update result, carryout, overflow and zero, and pulse done high for exactly the following cycle.
- Latency from start to done is WIDTH+1 edges.
REQ-019 overflow SHALL equal (carry into the MSB) XOR (carry out of the MSB) for ADD, SUB and SLT.
REQ-020 For SLT, result SHALL be {WIDTH-1 zeros, (MSB of A-B) XOR overflow}.
- carryout and overflow report the underlying subtraction.
REQ-021 For XOR, AND, NAND, NOR and OR, result SHALL be the bitwise function of A and B (XOR uses the uninverted B), with carryout=0 and overflow=0.
REQ-022 zero SHALL be derived from the final registered result, not from the slice zero chain, so it is correct for every command including SLT and the logic operations.
REQ-023 ready SHALL be 1 iff the state is IDLE.
- ready is 1 in the same cycle that done=1.
- A back-to-back start is accepted on the next edge.
- Back-to-back throughput is one operation per WIDTH+2 edges.
REQ-024 start while ready=0 SHALL be ignored (no queuing), and changes on a, b or command after E0 SHALL NOT affect the operation in flight.
REQ-025 result, carryout, overflow and zero SHALL hold their values from the last completed operation until the next FIN edge; they SHALL NOT change during RUN.
REQ-026 The clock period SHALL cover one slice evaluation plus register setup; the slice is the only combinational path between the operand shift registers and the carry/result registers.

Reset
REQ-027 While rst_n=0 (asynchronous, immediate), the block SHALL hold:
- state IDLE; ready=1; done=0;
- result=0; carryout=0; overflow=0; zero=1;
- carry register, bit index and latched operands = 0.
REQ-028 rst_n asserted mid-RUN or mid-FIN SHALL abort the operation with no done pulse; the first rising edge after rst_n returns high SHALL be able to accept a start.

Verification (WIDTH=32)
REQ-029 ADD a=0xFFFFFFFF, b=0x00000001 -> done exactly 33 edges after the start edge; result=0x00000000, carryout=1, overflow=0, zero=1.
REQ-030 SUB a=0x80000000, b=0x00000001 -> result=0x7FFFFFFF, carryout=1, overflow=1, zero=0.
REQ-031 SLT cases -> result as follows, carry/overflow per the subtraction:
- a=0xFFFFFFFB (-5), b=3 -> 0x00000001.
- a=3, b=0xFFFFFFFB -> 0x00000000, zero=1.
- a=0x80000000, b=1 -> 0x00000001 (overflow=1).
REQ-032 Logic ops with a=0xF0F0F0F0, b=0xFF00FF00 -> carryout=0 and overflow=0 for all five, and:
- XOR -> 0x0FF00FF0; AND -> 0xF000F000; NAND -> 0x0FFF0FFF; NOR -> 0x000F000F; OR -> 0xFFF0FFF0.
REQ-033 Start ADD 5+7, toggle start and change a/b/command during RUN -> single done pulse with result=12; second start held across the done cycle -> accepted at the next edge and done after another 33 edges.
REQ-034 Start SUB 9-4, drive rst_n=0 at edge 10 -> ready=1, done=0 and result=0 immediately with no later done pulse; release, start OR 1|2 -> result=0x00000003.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: sequences one 1-bit ALU slice over WIDTH bits, LSB first,
// then publishes result and flags together with a one-cycle done pulse.

module alu_bit_slice (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       invtb,
  input  logic [2:0] command,
  output logic       result,
  output logic       cout
);
  logic bb;
  logic sum;

  assign bb   = b ^ invtb;
  assign sum  = a ^ bb ^ cin;
  assign cout = (a & bb) | (a & cin) | (bb & cin);

  always_comb begin
    result = sum;
    case (command)
      3'd2:    result = a ^ b;
      3'd4:    result = a & b;
      3'd5:    result = ~(a & b);
      3'd6:    result = ~(a | b);
      3'd7:    result = a | b;
      default: result = sum;
    endcase
  end
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [2:0] CMD_SUB = 3'd1;
  localparam logic [2:0] CMD_SLT = 3'd3;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_reg;
  logic [2:0]       cmd_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic [IW-1:0]    idx_reg;
  logic             carry_reg;
  logic             cin_last_reg;

  logic             slice_res;
  logic             slice_cout;
  logic             invtb;
  logic             arith;
  logic             ovf_fin;
  logic [WIDTH-1:0] res_fin;

  assign ready = (state_reg == IDLE);
  assign invtb = (cmd_reg == CMD_SUB) || (cmd_reg == CMD_SLT);
  assign arith = (cmd_reg == 3'd0) || invtb;

  alu_bit_slice u_slice (
    .a       (a_sh_reg[0]),
    .b       (b_sh_reg[0]),
    .cin     (carry_reg),
    .invtb   (invtb),
    .command (cmd_reg),
    .result  (slice_res),
    .cout    (slice_cout)
  );

  // In FIN, carry_reg holds the MSB carry-out and cin_last_reg the carry into the MSB.
  assign ovf_fin = arith & (cin_last_reg ^ carry_reg);
  assign res_fin = (cmd_reg == CMD_SLT) ? {{(WIDTH-1){1'b0}}, res_sh_reg[WIDTH-1] ^ ovf_fin}
                                        : res_sh_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cmd_reg      <= '0;
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      res_sh_reg   <= '0;
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      cin_last_reg <= 1'b0;
      result       <= '0;
      carryout     <= 1'b0;
      overflow     <= 1'b0;
      zero         <= 1'b1;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            cmd_reg    <= command;
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            idx_reg    <= '0;
            carry_reg  <= (command == CMD_SUB) || (command == CMD_SLT);
            res_sh_reg <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          res_sh_reg[idx_reg] <= slice_res;
          carry_reg           <= slice_cout;
          cin_last_reg        <= carry_reg;
          a_sh_reg            <= a_sh_reg >> 1;
          b_sh_reg            <= b_sh_reg >> 1;
          idx_reg             <= idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) state_reg <= FIN;
        end
        FIN: begin
          result    <= res_fin;
          carryout  <= arith & carry_reg;
          overflow  <= ovf_fin;
          zero      <= (res_fin == '0);
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (WIDTH=32) with hand-computed expectations.

module tb_alu_serial_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  command = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready, done, carryout, overflow, zero;
  logic [31:0] result;

  int n_chk = 0;
  int n_fail = 0;
  int lat;
  int pulses;

  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .command(command),
    .a(a), .b(b), .ready(ready), .done(done), .result(result),
    .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] r, input logic c, input logic o,
                         input logic z);
    chk({tag, ".result"}, 64'(result), 64'(r));
    chk({tag, ".carryout"}, 64'(carryout), 64'(c));
    chk({tag, ".overflow"}, 64'(overflow), 64'(o));
    chk({tag, ".zero"}, 64'(zero), 64'(z));
  endtask

  // Caller is #1 after an edge with ready=1; returns #1 after the done edge.
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done && edges < 100);
  endtask

  task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] x,
                        input logic [31:0] y);
    int e;
    command = c; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; command = 3'($urandom_range(0, 7));
    wait_done(e);
    chk({tag, ".latency"}, 64'(e), 64'd33);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst.ready", 64'(ready), 64'd1);
    chk("rst.done", 64'(done), 64'd0);
    chk_out("rst", 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap", 3'd0, 32'hFFFFFFFF, 32'h00000001);
    chk_out("add_wrap", 32'h0, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf", 3'd0, 32'h7FFFFFFF, 32'h00000001);
    chk_out("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", 3'd1, 32'h80000000, 32'h00000001);
    chk_out("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_op("slt_m5_3", 3'd3, 32'hFFFFFFFB, 32'h00000003);
    chk_out("slt_m5_3", 32'h1, 1'b1, 1'b0, 1'b0);
    run_op("slt_3_m5", 3'd3, 32'h00000003, 32'hFFFFFFFB);
    chk_out("slt_3_m5", 32'h0, 1'b0, 1'b0, 1'b1);
    run_op("slt_min_1", 3'd3, 32'h80000000, 32'h00000001);
    chk_out("slt_min_1", 32'h1, 1'b1, 1'b1, 1'b0);

    run_op("xor", 3'd2, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_out("xor", 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
    run_op("and", 3'd4, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_out("and", 32'hF000F000, 1'b0, 1'b0, 1'b0);
    run_op("nand", 3'd5, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_out("nand", 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0);
    run_op("nor", 3'd6, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_out("nor", 32'h000F000F, 1'b0, 1'b0, 1'b0);
    run_op("or", 3'd7, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_out("or", 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);

    // ADD 5+7 with disturbed inputs during RUN; start then held across the done cycle.
    command = 3'd0; a = 32'd5; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("hold.ready", 64'(ready), 64'd0);
    chk("hold.result", 64'(result), 64'hFFF0FFF0);
    start = 1'b1; a = 32'd100; b = 32'd200; command = 3'd7;
    lat = 5;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b1.latency", 64'(lat), 64'd33);
    chk("b2b1.result", 64'(result), 64'd12);
    chk("b2b1.ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b1.done_pulse", 64'(done), 64'd0);
    chk("b2b2.accepted", 64'(ready), 64'd0);
    wait_done(lat);
    chk("b2b2.latency", 64'(lat), 64'd33);
    chk_out("b2b2", 32'h000000EC, 1'b0, 1'b0, 1'b0);

    // Reset mid-RUN aborts the SUB with no later done.
    command = 3'd1; a = 32'd9; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort.ready", 64'(ready), 64'd1);
    chk("abort.done", 64'(done), 64'd0);
    chk_out("abort", 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort.no_done", 64'(pulses), 64'd0);
    run_op("or_after_rst", 3'd7, 32'h1, 32'h2);
    chk_out("or_after_rst", 32'h3, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
